// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with enable, synchronous clamped load and registered terminal-count/zero flags.
// Defining PARAM_UPDOWN_COUNTER_SAT_EN selects saturating bounds instead of wrap-around.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] next_out;
  logic             next_tc;
  logic             at_max;
  logic             at_min;

  assign at_max = (out == MAX_W);
  assign at_min = (out == '0);

  // Priority is load over count; up only matters on an enabled count step.
  always_comb begin
    next_out = out;
    next_tc  = 1'b0;
    if (load) begin
      next_out = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (up) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        next_out = at_max ? out : out + ONE_W;
`else
        next_out = at_max ? '0 : out + ONE_W;
`endif
        next_tc  = at_max;
      end else begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        next_out = at_min ? out : out - ONE_W;
`else
        next_out = at_min ? MAX_W : out - ONE_W;
`endif
        next_tc  = at_min;
      end
    end
  end

  // zero is derived from next_out so it lines up with out in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= RST_W;
      tc   <= 1'b0;
      zero <= (RST_W == '0);
    end else begin
      out  <= next_out;
      tc   <= next_tc;
      zero <= (next_out == '0);
    end
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter; next generation of the fixed 4-bit down counter. Adds:
- configurable width and modulus
- runtime direction select
- count enable
- synchronous parallel load
- registered terminal-count pulse
Used as a generic timing/sequence counter across the lab designs: dividers, timeouts and address stepping.

Parameters:
- WIDTH, 4, counter bit width; 1..16.
- MAX_VAL, 2**WIDTH-1, highest count value; range is 0..MAX_VAL; 1 <= MAX_VAL <= 2**WIDTH-1.
- RST_VAL, 0, value loaded into out on reset; must be <= MAX_VAL.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable; a step is taken only when high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- out  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered
- zero  output  1  high when out == 0, registered

Behaviour:
- Reset (async, rst=1): out=RST_VAL, tc=0, zero=(RST_VAL==0). Held while rst is high. First update is on the first rising clk edge after rst deasserts.
- Priority at each rising edge: rst > load > en. up is sampled only when en is high and load is low.
- Load (load=1):
  - out <= min(load_val, MAX_VAL); values above MAX_VAL clamp to MAX_VAL.
  - tc <= 0.
  - en is ignored that cycle.
- Count (load=0, en=1, up=1):
  - out != MAX_VAL: out <= out+1, tc <= 0.
  - out == MAX_VAL: out <= 0, tc <= 1.
- Count (load=0, en=1, up=0):
  - out != 0: out <= out-1, tc <= 0.
  - out == 0: out <= MAX_VAL, tc <= 1.
- Hold (load=0, en=0): out unchanged, tc <= 0.
- tc timing:
  - Registered together with out, so tc is high in exactly the cycle out first shows the wrapped value.
  - Width is one cycle per wrap.
  - With en held high and MAX_VAL=1, tc is high on consecutive wraps.
- zero: registered copy of (next out == 0); always consistent with out in the same cycle.
- Direction change mid-count: takes effect on the same edge up is sampled. No pipeline and no extra latency; step latency is 1 cycle.
- Arithmetic:
  - Compare against MAX_VAL at WIDTH bits.
  - No intermediate overflow when MAX_VAL = 2**WIDTH-1; natural wrap matches the modulus.
- Reset mid-operation: out returns to RST_VAL immediately (asynchronously) and tc drops to 0. A pending load or step in that cycle is discarded.
- Default-parameter equivalence: WIDTH=4, MAX_VAL=15, en=1, up=0, load=0 reproduces the legacy 15→0 down sequence, wrapping 0→15.

Optional Feature:
- Macro: PARAM_UPDOWN_COUNTER_SAT_EN
- Defined: saturating mode.
  - Up at MAX_VAL holds MAX_VAL; down at 0 holds 0.
  - tc <= 1 for every enabled cycle in which a step is blocked by the bound; otherwise 0.
  - Load and hold behave as above.
- Undefined: wrap-around mode exactly as in Behaviour.
- The macro changes no ports.

Test Plan:
All with WIDTH=4, MAX_VAL=9, RST_VAL=0 unless stated.
1. Reset and async check:
   - rst=1 between edges -> out=0, tc=0, zero=1 before the next clk edge.
   - With RST_VAL=5 -> out=5, zero=0.
2. Up-count wrap:
   - en=1, up=1 for 12 cycles from 0 -> out 1..9, 0, 1, 2.
   - tc=1 only in the cycle out==0 after 9.
   - zero=1 in that same cycle.
3. Down-count wrap:
   - en=1, up=0 from 2 -> out 1, 0, 9, 8.
   - tc=1 only in the cycle out==9.
4. Load priority and clamp:
   - load=1, load_val=7, en=1, up=1 -> out=7 next cycle, tc=0.
   - load_val=14 -> out=9.
   - Then en=0 for 3 cycles -> out stays 9, tc=0.
5. Direction reversal and mid-operation reset:
   - At out=9 with up=1, en=1 -> out=0, tc=1.
   - Next cycle up=0 -> out=9, tc=1.
   - Assert rst mid-cycle at out=6 -> out=0, tc=0 immediately.
6. PARAM_UPDOWN_COUNTER_SAT_EN defined:
   - up=1 from 8 for 3 cycles -> out 9, 9, 9; tc 0, 1, 1.
   - Down from 1 for 3 cycles -> out 0, 0, 0; tc 0, 1, 1.
